// File: rtl/uart_rx_frame_ctrl.sv
// uart_rx_frame_ctrl: sequences uart_rx and assembles its bytes into command frames
// of the form SYNC, ID, LEN, payload[LEN], CHK, where CHK is the XOR of ID, LEN and
// the payload. A good frame is held on a valid/ready interface while the receiver
// is disabled. Malformed, interrupted or stalled frames raise a one-cycle frame_err
// and record an error code.
module uart_rx_frame_ctrl #(
   parameter int                         NUM_DATA_BITS  = 8,
   parameter int                         MAX_LEN        = 16,
   parameter logic [NUM_DATA_BITS-1:0]   SYNC_BYTE      = NUM_DATA_BITS'(8'hA5),
   parameter int                         TIMEOUT_CYCLES = 4096
) (
   input  logic                               clk,
   input  logic                               reset,
   output logic                               rx_enable,
   input  logic [NUM_DATA_BITS-1:0]           rx_data,
   input  logic                               rx_done,
   input  logic                               rx_error,
   output logic                               cmd_valid,
   input  logic                               cmd_ready,
   output logic [NUM_DATA_BITS-1:0]           cmd_id,
   output logic [$clog2(MAX_LEN+1)-1:0]       cmd_len,
   input  logic [$clog2(MAX_LEN)-1:0]         cmd_rd_idx,
   output logic [NUM_DATA_BITS-1:0]           cmd_rd_data,
   output logic                               frame_err,
   output logic [2:0]                         err_code,
   output logic [15:0]                        frame_cnt,
   output logic [15:0]                        err_cnt
);

   localparam int LEN_W = $clog2(MAX_LEN+1);
   localparam int IDX_W = $clog2(MAX_LEN);
   localparam int TMO_W = $clog2(TIMEOUT_CYCLES);

   localparam logic [TMO_W-1:0]         TMO_LAST  = TMO_W'(TIMEOUT_CYCLES-1);
   localparam logic [NUM_DATA_BITS-1:0] MAX_LEN_B = NUM_DATA_BITS'(MAX_LEN);

   localparam logic [2:0] ERR_NONE = 3'd0;
   localparam logic [2:0] ERR_LINE = 3'd1;
   localparam logic [2:0] ERR_LEN  = 3'd2;
   localparam logic [2:0] ERR_CHK  = 3'd3;
   localparam logic [2:0] ERR_TMO  = 3'd4;

   typedef enum logic [2:0] {
      S_HUNT    = 3'd0,
      S_ID      = 3'd1,
      S_LEN     = 3'd2,
      S_PAYLOAD = 3'd3,
      S_CHK     = 3'd4,
      S_HOLD    = 3'd5
   } state_t;

   // Running frame checksum: fold one more byte into the XOR accumulator.
   function automatic logic [NUM_DATA_BITS-1:0] xor_fold(
      input logic [NUM_DATA_BITS-1:0] acc,
      input logic [NUM_DATA_BITS-1:0] data_byte
   );
      return acc ^ data_byte;
   endfunction

   state_t                     state_q,     state_d;
   logic [NUM_DATA_BITS-1:0]   cmd_id_q,    cmd_id_d;
   logic [LEN_W-1:0]           cmd_len_q,   cmd_len_d;
   logic [LEN_W-1:0]           idx_q,       idx_d;
   logic [NUM_DATA_BITS-1:0]   xor_q,       xor_d;
   logic [TMO_W-1:0]           tmo_q,       tmo_d;
   logic [15:0]                frame_cnt_q, frame_cnt_d;
   logic [15:0]                err_cnt_q,   err_cnt_d;
   logic [2:0]                 err_code_q,  err_code_d;
   logic                       frame_err_q, frame_err_d;
   logic                       rx_enable_q, rx_enable_d;
   logic                       cmd_valid_q, cmd_valid_d;

   logic                       err_hit_s;
   logic [2:0]                 err_kind_s;
   logic                       buf_we_s;
   logic [IDX_W-1:0]           buf_waddr_s;
   logic [NUM_DATA_BITS-1:0]   buf_wdata_s;

   logic [NUM_DATA_BITS-1:0]   buf_q [MAX_LEN];

   // Frame sequencing: next state, field capture, checksum, inter-byte timeout and error detection.
   always_comb begin
      state_d     = state_q;
      cmd_id_d    = cmd_id_q;
      cmd_len_d   = cmd_len_q;
      idx_d       = idx_q;
      xor_d       = xor_q;
      tmo_d       = tmo_q;
      frame_cnt_d = frame_cnt_q;
      err_hit_s   = 1'b0;
      err_kind_s  = ERR_NONE;
      buf_we_s    = 1'b0;
      buf_waddr_s = idx_q[IDX_W-1:0];
      buf_wdata_s = rx_data;

      case (state_q)
         S_HUNT: begin
            tmo_d = {TMO_W{1'b0}};
            if (rx_error) begin
               err_hit_s  = 1'b1;
               err_kind_s = ERR_LINE;
            end else if (rx_done && (rx_data == SYNC_BYTE)) begin
               state_d = S_ID;
               xor_d   = {NUM_DATA_BITS{1'b0}};
            end else begin
               state_d = S_HUNT;
            end
         end

         S_ID, S_LEN, S_PAYLOAD, S_CHK: begin
            // A line error beats a byte; a byte beats the timeout.
            if (rx_error) begin
               err_hit_s  = 1'b1;
               err_kind_s = ERR_LINE;
               state_d    = S_HUNT;
               tmo_d      = {TMO_W{1'b0}};
            end else if (rx_done) begin
               tmo_d = {TMO_W{1'b0}};
               case (state_q)
                  S_ID: begin
                     cmd_id_d = rx_data;
                     xor_d    = rx_data;
                     state_d  = S_LEN;
                  end
                  S_LEN: begin
                     if (rx_data > MAX_LEN_B) begin
                        err_hit_s  = 1'b1;
                        err_kind_s = ERR_LEN;
                        state_d    = S_HUNT;
                     end else begin
                        cmd_len_d = rx_data[LEN_W-1:0];
                        xor_d     = xor_fold(xor_q, rx_data);
                        idx_d     = {LEN_W{1'b0}};
                        if (rx_data == {NUM_DATA_BITS{1'b0}}) begin
                           state_d = S_CHK;
                        end else begin
                           state_d = S_PAYLOAD;
                        end
                     end
                  end
                  S_PAYLOAD: begin
                     buf_we_s = 1'b1;
                     xor_d    = xor_fold(xor_q, rx_data);
                     idx_d    = idx_q + LEN_W'(1);
                     if ((idx_q + LEN_W'(1)) == cmd_len_q) begin
                        state_d = S_CHK;
                     end else begin
                        state_d = S_PAYLOAD;
                     end
                  end
                  S_CHK: begin
                     if (rx_data == xor_q) begin
                        state_d     = S_HOLD;
                        frame_cnt_d = frame_cnt_q + 16'd1;
                     end else begin
                        err_hit_s  = 1'b1;
                        err_kind_s = ERR_CHK;
                        state_d    = S_HUNT;
                     end
                  end
                  default: begin
                     state_d = S_HUNT;
                  end
               endcase
            end else if (tmo_q == TMO_LAST) begin
               err_hit_s  = 1'b1;
               err_kind_s = ERR_TMO;
               state_d    = S_HUNT;
               tmo_d      = {TMO_W{1'b0}};
            end else begin
               tmo_d = tmo_q + TMO_W'(1);
            end
         end

         S_HOLD: begin
            // Receiver is off here, so bytes and line errors are not seen.
            tmo_d = {TMO_W{1'b0}};
            if (cmd_valid_q && cmd_ready) begin
               state_d = S_HUNT;
            end else begin
               state_d = S_HOLD;
            end
         end

         default: begin
            state_d = S_HUNT;
            tmo_d   = {TMO_W{1'b0}};
         end
      endcase
   end

   // Registered-output targets: enable/valid follow the next state, error bookkeeping follows err_hit_s.
   always_comb begin
      rx_enable_d = (state_d != S_HOLD);
      cmd_valid_d = (state_d == S_HOLD);
      frame_err_d = err_hit_s;
      if (err_hit_s) begin
         err_code_d = err_kind_s;
         if (err_cnt_q == 16'hFFFF) begin
            err_cnt_d = err_cnt_q;
         end else begin
            err_cnt_d = err_cnt_q + 16'd1;
         end
      end else begin
         err_code_d = err_code_q;
         err_cnt_d  = err_cnt_q;
      end
   end

   // Control and status registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_HUNT;
         cmd_id_q    <= {NUM_DATA_BITS{1'b0}};
         cmd_len_q   <= {LEN_W{1'b0}};
         idx_q       <= {LEN_W{1'b0}};
         xor_q       <= {NUM_DATA_BITS{1'b0}};
         tmo_q       <= {TMO_W{1'b0}};
         frame_cnt_q <= 16'd0;
         err_cnt_q   <= 16'd0;
         err_code_q  <= ERR_NONE;
         frame_err_q <= 1'b0;
         rx_enable_q <= 1'b0;
         cmd_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cmd_id_q    <= cmd_id_d;
         cmd_len_q   <= cmd_len_d;
         idx_q       <= idx_d;
         xor_q       <= xor_d;
         tmo_q       <= tmo_d;
         frame_cnt_q <= frame_cnt_d;
         err_cnt_q   <= err_cnt_d;
         err_code_q  <= err_code_d;
         frame_err_q <= frame_err_d;
         rx_enable_q <= rx_enable_d;
         cmd_valid_q <= cmd_valid_d;
      end
   end

   // Payload buffer; contents are meaningless until a frame is complete, so it carries no reset.
   always_ff @(posedge clk) begin
      if (buf_we_s) begin
         buf_q[buf_waddr_s] <= buf_wdata_s;
      end
   end

   assign rx_enable   = rx_enable_q;
   assign cmd_valid   = cmd_valid_q;
   assign cmd_id      = cmd_id_q;
   assign cmd_len     = cmd_len_q;
   assign cmd_rd_data = buf_q[cmd_rd_idx];
   assign frame_err   = frame_err_q;
   assign err_code    = err_code_q;
   assign frame_cnt   = frame_cnt_q;
   assign err_cnt     = err_cnt_q;

endmodule
